// File: rtl/mem_pkg.sv
// Shared state encoding and default geometry for the code memory.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DEPTH  = 4096;

endpackage

// File: rtl/code_mem_bank.sv
// Word array, one byte-strobed write port and two combinational read ports.
// Write lands on the clock edge; reads are zero-latency, no backpressure.
module code_mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W/8-1:0]      wstrb_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_a_i,
    output logic [DATA_W-1:0]        rdata_a_o,
    input  logic [$clog2(DEPTH)-1:0] raddr_b_i,
    output logic [DATA_W-1:0]        rdata_b_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b]) begin
                    r_mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_a_o = r_mem[raddr_a_i];
    assign rdata_b_o = r_mem[raddr_b_i];

endmodule

// File: rtl/code_mem.sv
// Code/data memory: fetch port, data read port, strobed write port, optional zero-fill after reset.
// Reads return RD_LAT cycles after acceptance; writes always ready once initialised.
module code_mem
    import mem_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_strb_i,
    output logic                wr_err_o,
    input  logic                rd_valid_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic                rd_valid_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_err_o,
    input  logic                pc_valid_i,
    input  logic [ADDR_W-1:0]   pc_addr_i,
    output logic                inst_valid_o,
    output logic [DATA_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_addr_o,
    output logic                inst_err_o,
    output logic                init_done_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [NB-1:0]     strb);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic              r_init_done;
    logic              r_wr_err;
    logic              r_rd_v1, r_rd_e1, r_rd_vld, r_rd_err;
    logic [DATA_W-1:0] r_rd_d1, r_rd_dat;
    logic              r_pc_v1, r_pc_e1, r_pc_vld, r_pc_err;
    logic [DATA_W-1:0] r_pc_d1, r_inst;
    logic [ADDR_W-1:0] r_pc_a1, r_inst_addr;

    logic              w_clear, w_wr_acc, w_wr_bad, w_wr_en, w_wr_err;
    logic              w_rd_acc, w_rd_bad, w_pc_acc, w_pc_bad;
    logic [IDX_W-1:0]  w_bank_waddr;
    logic [DATA_W-1:0] w_bank_wdata, w_bank_rd, w_bank_pc, w_rd_new, w_pc_new;
    logic [NB-1:0]     w_bank_wstrb;
    logic              w_rd_sv, w_rd_se, w_pc_sv, w_pc_se;
    logic [DATA_W-1:0] w_rd_sd, w_pc_sd;
    logic [ADDR_W-1:0] w_pc_sa;

    assign w_clear  = (r_state == CLEAR);
    assign w_wr_acc = r_init_done && wr_valid_i;
    assign w_wr_bad = addr_bad(wr_addr_i);
    assign w_wr_en  = w_wr_acc && !w_wr_bad && (wr_strb_i != '0);
    assign w_wr_err = w_wr_acc &&  w_wr_bad && (wr_strb_i != '0);
    assign w_rd_acc = r_init_done && rd_valid_i;
    assign w_pc_acc = r_init_done && pc_valid_i;
    assign w_rd_bad = addr_bad(rd_addr_i);
    assign w_pc_bad = addr_bad(pc_addr_i);

    // The zero-fill sequence borrows the single write port of the bank.
    assign w_bank_waddr = w_clear ? r_clr_cnt : word_idx(wr_addr_i);
    assign w_bank_wdata = w_clear ? '0 : wr_data_i;
    assign w_bank_wstrb = w_clear ? '1 : wr_strb_i;

    code_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk_i     (clk_i),
        .we_i      (w_clear || w_wr_en),
        .waddr_i   (w_bank_waddr),
        .wdata_i   (w_bank_wdata),
        .wstrb_i   (w_bank_wstrb),
        .raddr_a_i (word_idx(rd_addr_i)),
        .rdata_a_o (w_bank_rd),
        .raddr_b_i (word_idx(pc_addr_i)),
        .rdata_b_o (w_bank_pc)
    );

    // Write-first: a same-cycle write to the same word is merged into the read result.
    always_comb begin
        w_rd_new = w_bank_rd;
        w_pc_new = w_bank_pc;
        if (w_wr_en && word_idx(wr_addr_i) == word_idx(rd_addr_i))
            w_rd_new = merge(w_bank_rd, wr_data_i, wr_strb_i);
        if (w_wr_en && word_idx(wr_addr_i) == word_idx(pc_addr_i))
            w_pc_new = merge(w_bank_pc, wr_data_i, wr_strb_i);
        if (w_rd_bad) w_rd_new = '0;
        if (w_pc_bad) w_pc_new = '0;
    end

    assign w_rd_sv = (RD_LAT == 1) ? w_rd_acc  : r_rd_v1;
    assign w_rd_se = (RD_LAT == 1) ? w_rd_bad  : r_rd_e1;
    assign w_rd_sd = (RD_LAT == 1) ? w_rd_new  : r_rd_d1;
    assign w_pc_sv = (RD_LAT == 1) ? w_pc_acc  : r_pc_v1;
    assign w_pc_se = (RD_LAT == 1) ? w_pc_bad  : r_pc_e1;
    assign w_pc_sd = (RD_LAT == 1) ? w_pc_new  : r_pc_d1;
    assign w_pc_sa = (RD_LAT == 1) ? pc_addr_i : r_pc_a1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + IDX_W'(1);
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN:     r_init_done <= 1'b1;
                default: r_state     <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_err    <= 1'b0;
            r_rd_v1     <= 1'b0;
            r_rd_e1     <= 1'b0;
            r_rd_d1     <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_err    <= 1'b0;
            r_rd_dat    <= '0;
            r_pc_v1     <= 1'b0;
            r_pc_e1     <= 1'b0;
            r_pc_d1     <= '0;
            r_pc_a1     <= '0;
            r_pc_vld    <= 1'b0;
            r_pc_err    <= 1'b0;
            r_inst      <= '0;
            r_inst_addr <= '0;
        end else begin
            r_wr_err <= w_wr_err;
            r_rd_v1  <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_d1 <= w_rd_new;
                r_rd_e1 <= w_rd_bad;
            end
            r_pc_v1 <= w_pc_acc;
            if (w_pc_acc) begin
                r_pc_d1 <= w_pc_new;
                r_pc_e1 <= w_pc_bad;
                r_pc_a1 <= pc_addr_i;
            end
            r_rd_vld <= w_rd_sv;
            r_rd_err <= w_rd_sv && w_rd_se;
            if (w_rd_sv) r_rd_dat <= w_rd_sd;
            r_pc_vld <= w_pc_sv;
            r_pc_err <= w_pc_sv && w_pc_se;
            if (w_pc_sv) begin
                r_inst      <= w_pc_sd;
                r_inst_addr <= w_pc_sa;
            end
        end
    end

    assign wr_ready_o   = r_init_done;
    assign init_done_o  = r_init_done;
    assign wr_err_o     = r_wr_err;
    assign rd_valid_o   = r_rd_vld;
    assign rd_data_o    = r_rd_dat;
    assign rd_err_o     = r_rd_err;
    assign inst_valid_o = r_pc_vld;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_err_o   = r_pc_err;

endmodule
